// File: rtl/bcd_to_bin_if.sv
// Handshake bundle between the BCD entry logic and the BCD-to-binary converter.
// The requester drives start/bcd_in; the converter returns the result and status flags.
interface bcd_to_bin_if #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic [BIN_W-1:0]      bin_out;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, bcd_in,
    input  bin_out, busy, done, err
  );

  modport slave (
    input  start, bcd_in,
    output bin_out, busy, done, err
  );
endinterface

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one bit per clock.
// Non-decimal digits are rejected at start with an immediate err/done pulse.
module bcd_to_bin #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic        clk,
  input  logic        reset,
  bcd_to_bin_if.slave bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic [SR_W-1:0]    sr_shift;

  function automatic logic all_decimal(input logic [BCD_W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  // Shift right one bit, then pull every BCD field that reached 8 or more back down by 3.
  function automatic logic [SR_W-1:0] shift_adjust(input logic [SR_W-1:0] sr);
    logic [SR_W-1:0] s;
    logic [3:0]      f;
    s = {1'b0, sr[SR_W-1:1]};
    for (int i = 0; i < DIGITS; i++) begin
      f = s[BIN_W + 4*i +: 4];
      if (f >= 4'd8) begin
        s[BIN_W + 4*i +: 4] = f - 4'd3;
      end else begin
        s[BIN_W + 4*i +: 4] = f;
      end
    end
    return s;
  endfunction

  // Next-state and next-output computation for the IDLE/SHIFT controller.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    err_d    = err_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    sr_shift = shift_adjust(sr_q);
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (all_decimal(bus.bcd_in)) begin
            sr_d    = {bus.bcd_in, {BIN_W{1'b0}}};
            cnt_d   = {CNT_W{1'b0}};
            busy_d  = 1'b1;
            state_d = S_SHIFT;
          end else begin
            bin_d   = {BIN_W{1'b0}};
            err_d   = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end else begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        sr_d  = sr_shift;
        cnt_d = cnt_q + CNT_W'(1);
        // The BIN_W-th shift leaves the whole value in the binary field.
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          bin_d   = sr_shift[BIN_W-1:0];
          err_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      default: begin
        sr_d    = {SR_W{1'b0}};
        cnt_d   = {CNT_W{1'b0}};
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sr_q    <= {SR_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      bin_q   <= {BIN_W{1'b0}};
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.bin_out = bin_q;
  assign bus.err     = err_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Scoreboard bench for bcd_to_bin: a cycle-level acceptance model pushes expected results,
// a monitor pops them when DONE appears; a 3-digit instance covers the wider configuration.
module tb_bcd_to_bin;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;

  bcd_to_bin_if #(.DIGITS(2), .BIN_W(7))  bus ();
  bcd_to_bin_if #(.DIGITS(3), .BIN_W(10)) bus3 ();

  bcd_to_bin #(.DIGITS(2), .BIN_W(7))  dut  (.clk(clk), .reset(reset), .bus(bus));
  bcd_to_bin #(.DIGITS(3), .BIN_W(10)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  typedef struct {
    int val;
    int err;
    int dcyc;
  } exp_t;

  exp_t sb[$];
  int   free_cyc;
  int   busy_lo;
  int   busy_hi;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Decimal value of a packed BCD word; err flags any digit above nine.
  function automatic int ref_conv(input logic [15:0] bcd, input int nd, output int err);
    int v;
    int p;
    int d;
    v   = 0;
    p   = 1;
    err = 0;
    for (int i = 0; i < nd; i++) begin
      d = int'(bcd[4*i +: 4]);
      if (d > 9) err = 1;
      v = v + d * p;
      p = p * 10;
    end
    return (err != 0) ? 0 : v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One negedge-aligned cycle of stimulus; the model decides whether START is taken.
  task automatic step(input logic s, input logic [7:0] b);
    int   e;
    int   v;
    exp_t x;
    bus.start  = s;
    bus.bcd_in = b;
    if (s && cyc >= free_cyc) begin
      v     = ref_conv({8'h00, b}, 2, e);
      x.val = v;
      x.err = e;
      if (e != 0) begin
        x.dcyc   = cyc + 1;
        free_cyc = cyc + 1;
      end else begin
        x.dcyc   = cyc + 1 + 7;
        busy_lo  = cyc + 1;
        busy_hi  = cyc + 7;
        free_cyc = cyc + 8;
      end
      sb.push_back(x);
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b);
    while (cyc < free_cyc) step(1'b0, 8'($urandom));
  endtask

  function automatic logic [7:0] rand_valid();
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'($urandom_range(9, 0));
    lo = 4'($urandom_range(9, 0));
    return {hi, lo};
  endfunction

  task automatic run3(input logic [11:0] b);
    int e;
    int v;
    int t0;
    int seen;
    v = ref_conv({4'h0, b}, 3, e);
    bus3.start  = 1'b1;
    bus3.bcd_in = b;
    t0 = cyc + 1;
    @(negedge clk);
    bus3.start = 1'b0;
    seen = 0;
    for (int n = 0; n < 20 && seen == 0; n++) begin
      if (bus3.done) seen = 1;
      else @(negedge clk);
    end
    check("dut3_done_seen", seen, 1);
    if (seen != 0) begin
      check("dut3_bin_out", int'(bus3.bin_out), v);
      check("dut3_err", int'(bus3.err), e);
      check("dut3_latency", cyc - t0, (e != 0) ? 0 : 10);
    end
    @(negedge clk);
  endtask

  // Scoreboard monitor: DONE must appear exactly when the model predicts it.
  always @(negedge clk) begin
    exp_t x;
    int   exp_done;
    if (!reset) begin
      check("busy", int'(bus.busy), (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
      exp_done = (sb.size() > 0 && sb[0].dcyc == cyc) ? 1 : 0;
      check("done", int'(bus.done), exp_done);
      if (exp_done != 0) begin
        x = sb.pop_front();
        if (bus.done) begin
          check("bin_out", int'(bus.bin_out), x.val);
          check("err", int'(bus.err), x.err);
        end
      end
    end
  end

  initial begin
    checks      = 0;
    errors      = 0;
    cyc         = 0;
    free_cyc    = 0;
    busy_lo     = 1;
    busy_hi     = 0;
    reset       = 1'b0;
    bus.start   = 1'b0;
    bus.bcd_in  = 8'h00;
    bus3.start  = 1'b0;
    bus3.bcd_in = 12'h000;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_bin_out", int'(bus.bin_out), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_err", int'(bus.err), 0);
    reset = 1'b0;
    @(negedge clk);

    send(8'h42);
    send(8'h99);
    send(8'h00);
    send(8'h3A);
    send(8'hA9);
    send(8'h07);

    // START held high while BCD_IN keeps changing.
    step(1'b1, 8'h12);
    for (int i = 0; i < 20; i++) step(1'b1, rand_valid());
    while (cyc < free_cyc) step(1'b0, 8'($urandom));

    for (int i = 0; i < 600; i++) step(1'($urandom), 8'($urandom));
    while (cyc < free_cyc) step(1'b0, 8'($urandom));

    for (int i = 0; i < 100; i++) send({4'(i / 10), 4'(i % 10)});

    // Asynchronous reset in the middle of a conversion.
    step(1'b1, 8'h77);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_bin_out", int'(bus.bin_out), 0);
    check("arst_busy", int'(bus.busy), 0);
    check("arst_done", int'(bus.done), 0);
    check("arst_err", int'(bus.err), 0);
    sb.delete();
    busy_lo  = 1;
    busy_hi  = 0;
    free_cyc = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) step(1'b0, 8'h00);
    send(8'h55);

    for (int n = 0; n < 30 && sb.size() > 0; n++) step(1'b0, 8'h00);
    check("drain_pending", sb.size(), 0);

    run3(12'h999);
    run3(12'h000);
    run3(12'h123);
    run3(12'h9A9);
    for (int i = 0; i < 5; i++) run3({4'($urandom_range(9, 0)), 4'($urandom_range(9, 0)), 4'($urandom_range(9, 0))});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
